// File: rtl/fml_width_bridge_pkg.sv
// Shared types and sizing helpers for the FML width bridge.
// State encoding plus derived widths for beat index and timeout counter.
package fml_bridge_pkg;

  localparam int DEFAULT_ADR_W = 26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_ACK,
    ST_COOL
  } state_t;

  function automatic int calc_ratio(input int bus_dw, input int ddr_dw);
    return bus_dw / ddr_dw;
  endfunction

  function automatic int calc_beat_w(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  function automatic int calc_tmo_w(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/fml_width_bridge_if.sv
// FML bus-side and DDR-side signals of the width bridge in one bundle.
// The bridge uses the slave view; the arbiter/DDR environment uses master.
interface fml_width_bridge_if #(
  parameter int ADR_W  = 26,
  parameter int BUS_DW = 32,
  parameter int DDR_DW = 16
);
  logic [ADR_W-1:0]    fml_adr_bus;
  logic                fml_stb_bus;
  logic                fml_we_bus;
  logic [BUS_DW/8-1:0] fml_sel_bus;
  logic [BUS_DW-1:0]   fml_di_bus;
  logic                fml_ack_bus;
  logic                fml_err_bus;
  logic [BUS_DW-1:0]   fml_do_bus;

  logic                fml_stb_ddr;
  logic                fml_we_ddr;
  logic [ADR_W-1:0]    fml_adr_ddr;
  logic [DDR_DW/8-1:0] fml_sel_ddr;
  logic [DDR_DW-1:0]   fml_do_ddr;
  logic                fml_ack_ddr;
  logic [DDR_DW-1:0]   fml_di_ddr;

  modport slave (
    input  fml_adr_bus, fml_stb_bus, fml_we_bus, fml_sel_bus, fml_di_bus,
    output fml_ack_bus, fml_err_bus, fml_do_bus,
    output fml_stb_ddr, fml_we_ddr, fml_adr_ddr, fml_sel_ddr, fml_do_ddr,
    input  fml_ack_ddr, fml_di_ddr
  );

  modport master (
    output fml_adr_bus, fml_stb_bus, fml_we_bus, fml_sel_bus, fml_di_bus,
    input  fml_ack_bus, fml_err_bus, fml_do_bus,
    input  fml_stb_ddr, fml_we_ddr, fml_adr_ddr, fml_sel_ddr, fml_do_ddr,
    output fml_ack_ddr, fml_di_ddr
  );

endinterface

// File: rtl/fml_width_bridge_timeout_counter.sv
// Counts cycles a DDR strobe stays unacknowledged; expires on the
// TIMEOUT-th cycle and saturates there until reloaded.
module fml_timeout_counter
  import fml_bridge_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = calc_tmo_w(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  assign o_expire = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fml_width_bridge.sv
// Splits each BUS_DW-wide FML transaction into RATIO narrower DDR beats,
// big-endian, reassembling read data and skipping empty write beats.
module fml_width_bridge
  import fml_bridge_pkg::*;
#(
  parameter int ADR_W   = DEFAULT_ADR_W,
  parameter int BUS_DW  = 32,
  parameter int DDR_DW  = 16,
  parameter int TIMEOUT = 0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  fml_width_bridge_if.slave fml
);

  localparam int RATIO  = calc_ratio(BUS_DW, DDR_DW);
  localparam int BEAT_W = calc_beat_w(RATIO);
  localparam int BUS_SW = BUS_DW / 8;
  localparam int DDR_SW = DDR_DW / 8;
  localparam logic [ADR_W-1:0]  ALIGN_MASK = ~ADR_W'(BUS_SW - 1);
  localparam logic [BUS_DW-1:0] SLICE_MASK = BUS_DW'({DDR_DW{1'b1}});

  state_t              r_state;
  state_t              w_next;
  logic [ADR_W-1:0]    r_adr;
  logic                r_we;
  logic [BUS_SW-1:0]   r_sel;
  logic [BUS_DW-1:0]   r_wdat;
  logic [BEAT_W-1:0]   r_beat;
  logic [BUS_DW-1:0]   r_rbuf;
  logic                r_err;

  logic                r_ack_bus;
  logic                r_err_bus;
  logic [BUS_DW-1:0]   r_do_bus;
  logic                r_stb_ddr;
  logic                r_we_ddr;
  logic [ADR_W-1:0]    r_adr_ddr;
  logic [DDR_SW-1:0]   r_sel_ddr;
  logic [DDR_DW-1:0]   r_do_ddr;

  logic [ADR_W-1:0]    w_src_adr;
  logic                w_src_we;
  logic [BUS_SW-1:0]   w_src_sel;
  logic [BUS_DW-1:0]   w_src_wdat;
  int                  w_start;
  logic                w_found;
  logic [BEAT_W-1:0]   w_next_k;
  int                  w_dsh;
  int                  w_ssh;
  int                  w_rsh;
  logic [ADR_W-1:0]    w_beat_adr;
  logic [DDR_SW-1:0]   w_beat_sel;
  logic [DDR_DW-1:0]   w_beat_dat;
  logic [BUS_DW-1:0]   w_rbuf_next;
  logic                w_err_next;
  logic                w_expire;

  // In IDLE the beat search looks at the live bus request; afterwards at the captured copy.
  always_comb begin
    w_src_adr  = r_adr;
    w_src_we   = r_we;
    w_src_sel  = r_sel;
    w_src_wdat = r_wdat;
    w_start    = int'(r_beat) + 1;
    if (r_state == ST_IDLE) begin
      w_src_adr  = fml.fml_adr_bus & ALIGN_MASK;
      w_src_we   = fml.fml_we_bus;
      w_src_sel  = fml.fml_sel_bus;
      w_src_wdat = fml.fml_di_bus;
      w_start    = 0;
    end
  end

  always_comb begin
    w_found  = 1'b0;
    w_next_k = '0;
    for (int k = RATIO - 1; k >= 0; k--) begin
      if (k >= w_start &&
          (!w_src_we || DDR_SW'(w_src_sel >> ((RATIO - 1 - k) * DDR_SW)) != '0)) begin
        w_found  = 1'b1;
        w_next_k = BEAT_W'(k);
      end
    end
  end

  assign w_dsh      = (RATIO - 1 - int'(w_next_k)) * DDR_DW;
  assign w_ssh      = (RATIO - 1 - int'(w_next_k)) * DDR_SW;
  assign w_rsh      = (RATIO - 1 - int'(r_beat)) * DDR_DW;
  assign w_beat_dat = DDR_DW'(w_src_wdat >> w_dsh);
  assign w_beat_sel = w_src_we ? DDR_SW'(w_src_sel >> w_ssh) : '1;
  assign w_beat_adr = w_src_adr + ADR_W'(int'(w_next_k) * DDR_SW);

  // A DDR ack wins over a timeout expiring in the same cycle.
  always_comb begin
    w_next      = r_state;
    w_rbuf_next = r_rbuf;
    w_err_next  = r_err;
    case (r_state)
      ST_IDLE: begin
        if (fml.fml_stb_bus) begin
          w_err_next = 1'b0;
          w_next     = w_found ? ST_REQ : ST_ACK;
        end
      end
      ST_REQ: begin
        if (fml.fml_ack_ddr) begin
          if (!r_we) begin
            w_rbuf_next = (r_rbuf & ~(SLICE_MASK << w_rsh)) |
                          (BUS_DW'(fml.fml_di_ddr) << w_rsh);
          end
          w_next = w_found ? ST_GAP : ST_ACK;
        end else if (w_expire) begin
          w_err_next  = 1'b1;
          w_rbuf_next = '0;
          w_next      = ST_ACK;
        end
      end
      ST_GAP:  w_next = w_found ? ST_REQ : ST_ACK;
      ST_ACK:  w_next = ST_COOL;
      ST_COOL: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  generate
    if (TIMEOUT > 0) begin : g_tmo
      fml_timeout_counter #(
        .TIMEOUT(TIMEOUT)
      ) u_tmo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .i_load  ((w_next == ST_REQ) && (r_state != ST_REQ)),
        .i_en    (r_state == ST_REQ),
        .o_expire(w_expire)
      );
    end else begin : g_no_tmo
      assign w_expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= ST_IDLE;
      r_adr     <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_wdat    <= '0;
      r_beat    <= '0;
      r_rbuf    <= '0;
      r_err     <= 1'b0;
      r_ack_bus <= 1'b0;
      r_err_bus <= 1'b0;
      r_do_bus  <= '0;
      r_stb_ddr <= 1'b0;
      r_we_ddr  <= 1'b0;
      r_adr_ddr <= '0;
      r_sel_ddr <= '0;
      r_do_ddr  <= '0;
    end else begin
      r_state   <= w_next;
      r_rbuf    <= w_rbuf_next;
      r_err     <= w_err_next;
      r_stb_ddr <= (w_next == ST_REQ);
      r_ack_bus <= (w_next == ST_ACK);
      r_err_bus <= (w_next == ST_ACK) ? w_err_next : 1'b0;
      if (w_next == ST_ACK) begin
        r_do_bus <= w_rbuf_next;
      end
      if (r_state == ST_IDLE && fml.fml_stb_bus) begin
        r_adr  <= w_src_adr;
        r_we   <= w_src_we;
        r_sel  <= w_src_sel;
        r_wdat <= w_src_wdat;
        r_beat <= '0;
      end
      if (w_next == ST_REQ && r_state != ST_REQ) begin
        r_beat    <= w_next_k;
        r_we_ddr  <= w_src_we;
        r_adr_ddr <= w_beat_adr;
        r_sel_ddr <= w_beat_sel;
        r_do_ddr  <= w_beat_dat;
      end
    end
  end

  assign fml.fml_ack_bus = r_ack_bus;
  assign fml.fml_err_bus = r_err_bus;
  assign fml.fml_do_bus  = r_do_bus;
  assign fml.fml_stb_ddr = r_stb_ddr;
  assign fml.fml_we_ddr  = r_we_ddr;
  assign fml.fml_adr_ddr = r_adr_ddr;
  assign fml.fml_sel_ddr = r_sel_ddr;
  assign fml.fml_do_ddr  = r_do_ddr;

endmodule

// File: tb/tb_fml_width_bridge.sv
// Self-checking bench for fml_width_bridge (32-bit bus, 16-bit DDR, timeout 8)
// against a transaction-level model of beats, timing and returned data.
module tb_fml_width_bridge;

  localparam int ADR_W   = 16;
  localparam int BUS_DW  = 32;
  localparam int DDR_DW  = 16;
  localparam int TIMEOUT = 8;
  localparam int RATIO   = BUS_DW / DDR_DW;
  localparam int NEVER   = 1000;

  typedef struct {
    logic [ADR_W-1:0] adr;
    logic             we;
    logic [1:0]       sel;
    logic [15:0]      dat;
  } beat_t;

  logic sysClk = 1'b0;
  logic sysRst = 1'b1;
  int   cycle = 0;
  int   checkCount = 0;
  int   failCount = 0;

  beat_t       obsQ[$];
  int          waitQ[$];
  logic [15:0] diQ[$];
  int          stbCycles = 0;
  int          gapViol = 0;

  fml_width_bridge_if #(.ADR_W(ADR_W), .BUS_DW(BUS_DW), .DDR_DW(DDR_DW)) fml ();

  fml_width_bridge #(
    .ADR_W  (ADR_W),
    .BUS_DW (BUS_DW),
    .DDR_DW (DDR_DW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk(sysClk),
    .sys_rst(sysRst),
    .fml    (fml)
  );

  // Free-running clock and cycle counter used for latency measurement.
  always #5 sysClk = ~sysClk;
  always @(posedge sysClk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // DDR responder: acks each beat after a scripted number of strobe cycles
  // and records every accepted beat together with any back-to-back strobes.
  initial begin
    int    curWait;
    int    cnt;
    logic  inBeat;
    logic  prevAck;
    beat_t b;
    curWait = 0;
    cnt     = 0;
    inBeat  = 1'b0;
    prevAck = 1'b0;
    fml.fml_ack_ddr = 1'b0;
    fml.fml_di_ddr  = '0;
    forever begin
      @(negedge sysClk);
      if (prevAck && fml.fml_stb_ddr) gapViol++;
      prevAck = 1'b0;
      fml.fml_ack_ddr = 1'b0;
      if (fml.fml_stb_ddr) begin
        stbCycles++;
        if (!inBeat) begin
          inBeat = 1'b1;
          cnt    = 0;
          if (waitQ.size() > 0) curWait = waitQ.pop_front();
          else curWait = NEVER;
        end
        if (cnt == curWait) begin
          b.adr = fml.fml_adr_ddr;
          b.we  = fml.fml_we_ddr;
          b.sel = fml.fml_sel_ddr;
          b.dat = fml.fml_do_ddr;
          obsQ.push_back(b);
          if (diQ.size() > 0) fml.fml_di_ddr = diQ.pop_front();
          else fml.fml_di_ddr = 16'hDEAD;
          fml.fml_ack_ddr = 1'b1;
          prevAck = 1'b1;
          inBeat  = 1'b0;
        end else begin
          cnt++;
        end
      end else begin
        inBeat = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_bus"}, {fml.fml_ack_bus, fml.fml_err_bus, fml.fml_do_bus}, 0);
    checkOutput({tag, "_ddr"}, {fml.fml_stb_ddr, fml.fml_we_ddr, fml.fml_adr_ddr,
                                fml.fml_sel_ddr, fml.fml_do_ddr}, 0);
  endtask

  // One bus transaction: the model derives the expected DDR beats, bus ack
  // cycle, error and read word from the request and the scripted DDR waits.
  task automatic applyStimulus(input string tag, input logic we, input logic [15:0] adr,
                               input logic [3:0] sel, input logic [31:0] wdat,
                               input int w0, input int w1,
                               input logic [15:0] d0, input logic [15:0] d1);
    beat_t       expBeat[RATIO];
    int          waits[RATIO];
    logic [15:0] dats[RATIO];
    logic [15:0] alignedAdr;
    logic [1:0]  s;
    int          nExp, nAcked, t, a, expLat, expStb, t0, lat, stbBase, gapBase;
    logic        expErr, seen, gotErr;
    logic [31:0] expDo, gotDo;

    waits[0] = w0; waits[1] = w1;
    dats[0]  = d0; dats[1]  = d1;
    alignedAdr = adr & 16'hFFFC;
    nExp = 0;
    for (int k = 0; k < RATIO; k++) begin
      s = sel[3 - 2 * k -: 2];
      if (!we || s != 2'b00) begin
        expBeat[nExp].adr = alignedAdr + 16'(2 * k);
        expBeat[nExp].we  = we;
        expBeat[nExp].sel = we ? s : 2'b11;
        expBeat[nExp].dat = wdat[31 - 16 * k -: 16];
        nExp++;
      end
    end

    t = 1; a = 0; expLat = 1; expStb = 0; nAcked = 0; expErr = 1'b0; expDo = '0;
    for (int i = 0; i < nExp; i++) begin
      if (waits[i] >= TIMEOUT) begin
        expLat = t + TIMEOUT;
        expStb += TIMEOUT;
        expErr = 1'b1;
        break;
      end
      a = t + waits[i];
      expStb += waits[i] + 1;
      expDo[31 - 16 * i -: 16] = dats[i];
      nAcked++;
      expLat = a + 1;
      t = a + 2;
    end
    if (expErr) expDo = '0;

    obsQ.delete();
    waitQ.delete();
    diQ.delete();
    for (int i = 0; i < nExp; i++) begin
      waitQ.push_back(waits[i]);
      diQ.push_back(dats[i]);
    end

    @(negedge sysClk);
    stbBase = stbCycles;
    gapBase = gapViol;
    t0 = cycle;
    fml.fml_adr_bus = adr;
    fml.fml_we_bus  = we;
    fml.fml_sel_bus = sel;
    fml.fml_di_bus  = wdat;
    fml.fml_stb_bus = 1'b1;
    seen = 1'b0; lat = -1; gotErr = 1'b0; gotDo = '0;
    for (int n = 0; n < 80; n++) begin
      @(negedge sysClk);
      if (n == 0) begin
        fml.fml_stb_bus = 1'b0;
        fml.fml_adr_bus = 16'($urandom);
        fml.fml_we_bus  = 1'($urandom);
        fml.fml_sel_bus = 4'($urandom);
        fml.fml_di_bus  = $urandom;
      end
      if (fml.fml_ack_bus) begin
        seen   = 1'b1;
        lat    = cycle - t0;
        gotErr = fml.fml_err_bus;
        gotDo  = fml.fml_do_bus;
        break;
      end
    end

    checkOutput({tag, "_ackSeen"}, seen, 1'b1);
    if (!seen) begin
      sysRst = 1'b1;
      @(negedge sysClk);
      sysRst = 1'b0;
      return;
    end
    checkOutput({tag, "_ackCycle"}, lat, expLat);
    checkOutput({tag, "_err"}, gotErr, expErr);
    if (!we) checkOutput({tag, "_rdata"}, gotDo, expDo);
    checkOutput({tag, "_beatCount"}, obsQ.size(), nAcked);
    for (int i = 0; i < nAcked && i < obsQ.size(); i++) begin
      checkOutput({tag, "_beatAdr"}, obsQ[i].adr, expBeat[i].adr);
      checkOutput({tag, "_beatWe"},  obsQ[i].we,  expBeat[i].we);
      checkOutput({tag, "_beatSel"}, obsQ[i].sel, expBeat[i].sel);
      if (we) checkOutput({tag, "_beatDat"}, obsQ[i].dat, expBeat[i].dat);
    end
    checkOutput({tag, "_stbCycles"}, stbCycles - stbBase, expStb);
    checkOutput({tag, "_stbGap"}, gapViol - gapBase, 0);

    @(negedge sysClk);
    checkOutput({tag, "_ackPulse"}, {fml.fml_ack_bus, fml.fml_err_bus}, 2'b00);
  endtask

  task automatic randWait(output int w);
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) w = r % 4;
    else if (r < 16) w = TIMEOUT - 1;
    else if (r < 17) w = NEVER;
    else w = 0;
  endtask

  initial begin
    int ackCount;
    int w0, w1;
    logic [3:0] rsel;
    fml.fml_adr_bus = '0;
    fml.fml_stb_bus = 1'b0;
    fml.fml_we_bus  = 1'b0;
    fml.fml_sel_bus = '0;
    fml.fml_di_bus  = '0;
    sysRst = 1'b1;
    repeat (3) @(negedge sysClk);
    checkAllZero("reset");
    sysRst = 1'b0;
    @(negedge sysClk);

    applyStimulus("rd100",    1'b0, 16'h0100, 4'hF, 32'h0, 0, 0, 16'h1234, 16'h5678);
    applyStimulus("wrFull",   1'b1, 16'h0200, 4'b1111, 32'hCAFEBABE, 0, 0, 16'h0, 16'h0);
    applyStimulus("wrLow",    1'b1, 16'h0200, 4'b0011, 32'hCAFEBABE, 0, 0, 16'h0, 16'h0);
    applyStimulus("wrHigh",   1'b1, 16'h0203, 4'b1000, 32'h89ABCDEF, 1, 0, 16'h0, 16'h0);
    applyStimulus("wrNone",   1'b1, 16'h0200, 4'b0000, 32'hCAFEBABE, 0, 0, 16'h0, 16'h0);
    applyStimulus("rdTmo",    1'b0, 16'h0300, 4'hF, 32'h0, NEVER, 0, 16'h1111, 16'h2222);
    applyStimulus("rdAfter",  1'b0, 16'h0304, 4'hF, 32'h0, 2, 1, 16'hA5A5, 16'h5A5A);
    applyStimulus("rdLastOk", 1'b0, 16'h0400, 4'hF, 32'h0, TIMEOUT - 1, 0, 16'hBEEF, 16'hF00D);
    applyStimulus("rdTmo2",   1'b0, 16'h0500, 4'hF, 32'h0, 0, NEVER, 16'h1357, 16'h2468);
    applyStimulus("rdTop",    1'b0, 16'hFFFF, 4'hF, 32'h0, 0, 0, 16'h0F0F, 16'hF0F0);

    // Reset while the first DDR beat is outstanding.
    waitQ.delete();
    waitQ.push_back(NEVER);
    obsQ.delete();
    @(negedge sysClk);
    fml.fml_adr_bus = 16'h0600;
    fml.fml_we_bus  = 1'b0;
    fml.fml_sel_bus = 4'hF;
    fml.fml_stb_bus = 1'b1;
    @(negedge sysClk);
    fml.fml_stb_bus = 1'b0;
    checkOutput("rstMid_stbBefore", fml.fml_stb_ddr, 1'b1);
    sysRst = 1'b1;
    @(negedge sysClk);
    sysRst = 1'b0;
    checkAllZero("rstMid");
    ackCount = 0;
    repeat (12) begin
      @(negedge sysClk);
      if (fml.fml_ack_bus || fml.fml_stb_ddr) ackCount++;
    end
    checkOutput("rstMid_noActivity", ackCount, 0);
    applyStimulus("rdPostRst", 1'b0, 16'h0700, 4'hF, 32'h0, 1, 0, 16'hC0DE, 16'hD00D);

    for (int i = 0; i < 40; i++) begin
      randWait(w0);
      randWait(w1);
      rsel = 4'($urandom);
      if ($urandom_range(0, 5) == 0) rsel = 4'b0000;
      applyStimulus("rand", 1'($urandom), 16'($urandom), rsel, $urandom, w0, w1,
                    16'($urandom), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
